// File: rtl/sbox6_layer_seq.sv
// sbox6_layer_seq: applies the 6-bit power-13 S-box to every 6-bit lane of a
// wide state. One S-box instance is shared across the lanes, one lane per cycle.
// Field: GF(2^6) with reduction polynomial x^6 + x + 1, so S(x) = x^13 there.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. The producer holds data stable while valid is high and ready is
// low. in_ready is high only in IDLE. out_valid is high only in DONE, and
// out_data stays stable until the transfer completes.
module sbox6_layer_seq #(
  parameter int LANES = 8,
  parameter int PIPE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6*LANES-1:0]   in_data,
  input  logic [LANES-1:0]     in_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [6*LANES-1:0]   out_data,
  output logic                 busy
);

  localparam int W  = 6 * LANES;
  localparam int CW = $clog2(LANES + 2);
  localparam logic [CW-1:0] LANES_C = CW'(LANES);
  localparam logic [CW-1:0] LAST_M1 = CW'(LANES + PIPE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Carry-less 6x6 product followed by reduction by x^6 + x + 1.
  function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
    logic [10:0] p;
    p = '0;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) p = p ^ ({5'b0, a} << i);
    end
    for (int i = 10; i >= 6; i--) begin
      if (p[i]) p = p ^ (11'h043 << (i - 6));
    end
    return p[5:0];
  endfunction

  // x^13 = x^8 * x^4 * x, built from three squarings and two products.
  function automatic logic [5:0] sbox(input logic [5:0] x);
    logic [5:0] x2, x4, x8, x12;
    x2  = gf_mul(x, x);
    x4  = gf_mul(x2, x2);
    x8  = gf_mul(x4, x4);
    x12 = gf_mul(x8, x4);
    return gf_mul(x12, x);
  endfunction

  state_e          state_q, state_d;
  logic [W-1:0]    sh_q, sh_d;
  logic [LANES-1:0] mk_q, mk_d;
  logic [CW-1:0]   iss_q, iss_d;
  logic [CW-1:0]   wb_q, wb_d;
  logic [5:0]      pipe_q, pipe_d;
  logic [W-1:0]    out_q, out_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [5:0]      lane_in;
  logic [5:0]      lane_sub;
  logic [5:0]      wb_lane;

  // Shared S-box on the low lane; the lane bypasses it when its mask bit is 0.
  always_comb begin
    lane_in  = sh_q[5:0];
    lane_sub = mk_q[0] ? sbox(lane_in) : lane_in;
    wb_lane  = (PIPE != 0) ? pipe_q : lane_sub;
  end

  // Next-state logic: capture in IDLE, rotate/substitute in RUN, hold in DONE.
  // With PIPE=1 the first write-back carries a stale lane into the top slot;
  // the extra (LANES+1)th rotation pushes it out the bottom again.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    mk_d        = mk_q;
    iss_d       = iss_q;
    wb_d        = wb_q;
    pipe_d      = pipe_q;
    out_d       = out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sh_d       = in_data;
          mk_d       = in_mask;
          iss_d      = '0;
          wb_d       = '0;
          pipe_d     = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        sh_d = {wb_lane, sh_q[W-1:6]};
        if (iss_q != LANES_C) begin
          mk_d   = {mk_q[0], mk_q[LANES-1:1]};
          iss_d  = iss_q + CW'(1);
          pipe_d = lane_sub;
        end
        wb_d = wb_q + CW'(1);
        if (wb_q == LAST_M1) begin
          state_d     = DONE;
          out_d       = {wb_lane, sh_q[W-1:6]};
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      mk_q        <= '0;
      iss_q       <= '0;
      wb_q        <= '0;
      pipe_q      <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      mk_q        <= mk_d;
      iss_q       <= iss_d;
      wb_q        <= wb_d;
      pipe_q      <= pipe_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sbox6_layer_seq.sv
// Bench for sbox6_layer_seq: one PIPE=0 and one PIPE=1 instance share the same
// stimulus. The driver pushes expected results, and a monitor pops and compares them.
module tb_sbox6_layer_seq;

  localparam int L = 8;
  localparam int W = 6 * L;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          in_valid, out_ready;
  logic [W-1:0]  in_data;
  logic [L-1:0]  in_mask;
  logic          in_ready0, out_valid0, busy0;
  logic          in_ready1, out_valid1, busy1;
  logic [W-1:0]  out_data0, out_data1;

  sbox6_layer_seq #(.LANES(L), .PIPE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_mask(in_mask), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .busy(busy0)
  );

  sbox6_layer_seq #(.LANES(L), .PIPE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_mask(in_mask), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .busy(busy1)
  );

  // ---------------- reference model ----------------
  // Shift-and-add multiply, reducing with x^6 = x + 1 after every step.
  function automatic logic [5:0] m_mul(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] r, x;
    r = '0;
    x = a;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) r = r ^ x;
      x = x[5] ? ((x << 1) ^ 6'h03) : (x << 1);
    end
    return r;
  endfunction

  function automatic logic [5:0] m_sbox(input logic [5:0] x);
    logic [5:0] r;
    r = 6'd1;
    for (int i = 0; i < 13; i++) r = m_mul(r, x);
    return r;
  endfunction

  function automatic logic [W-1:0] m_state(input logic [W-1:0] d, input logic [L-1:0] m);
    logic [W-1:0] r;
    r = d;
    for (int k = 0; k < L; k++) begin
      if (m[k]) r[6*k +: 6] = m_sbox(d[6*k +: 6]);
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp0_q[$], exp1_q[$];
  int           acc0_q[$], acc1_q[$];
  bit           tag0_q[$], tag1_q[$];
  bit           seen[64];
  int           hs_cyc1 = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic         pv[2]  = '{1'b0, 1'b0};
  logic         phs[2] = '{1'b0, 1'b0};
  logic [W-1:0] pd[2];

  task automatic mon(input int id, input logic ov, input logic ir, input logic bs,
                     input logic [W-1:0] od);
    logic [W-1:0] e;
    int a;
    bit t;
    chk(id == 0 ? "ready_vs_busy0" : "ready_vs_busy1", W'(ir), W'(!bs));
    if (ov && !pv[id]) begin
      if ((id == 0 ? acc0_q.size() : acc1_q.size()) == 0) begin
        chk(id == 0 ? "spurious_valid0" : "spurious_valid1", W'(1), W'(0));
      end else begin
        a = (id == 0) ? acc0_q.pop_front() : acc1_q.pop_front();
        chk(id == 0 ? "latency0" : "latency1", W'(cyc - a), W'(L + id));
      end
    end
    if (ov && pv[id] && !phs[id]) chk(id == 0 ? "hold_data0" : "hold_data1", od, pd[id]);
    if (ov && out_ready) begin
      if ((id == 0 ? exp0_q.size() : exp1_q.size()) == 0) begin
        chk(id == 0 ? "unexpected_out0" : "unexpected_out1", W'(1), W'(0));
      end else begin
        e = (id == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
        t = (id == 0) ? tag0_q.pop_front() : tag1_q.pop_front();
        chk(id == 0 ? "out_data0" : "out_data1", od, e);
        if (t && id == 0) begin
          for (int k = 0; k < L; k++) seen[od[6*k +: 6]] = 1'b1;
        end
        if (id == 1) hs_cyc1 = cyc + 1;
      end
    end
    pv[id]  = ov;
    phs[id] = ov && out_ready;
    pd[id]  = od;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, out_valid0, in_ready0, busy0, out_data0);
      mon(1, out_valid1, in_ready1, busy1, out_data1);
    end
  end

  // ---------------- driver tasks ----------------
  int last_acc = 0;

  task automatic send(input logic [W-1:0] d, input logic [L-1:0] m,
                      input logic [W-1:0] e, input bit tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(in_ready0 && in_ready1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", W'(0), W'(1));
    in_valid = 1'b1;
    in_data  = d;
    in_mask  = m;
    exp0_q.push_back(e); exp1_q.push_back(e);
    tag0_q.push_back(tag); tag1_q.push_back(tag);
    @(posedge clk);
    #1;
    last_acc = cyc;
    acc0_q.push_back(cyc); acc1_q.push_back(cyc);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!(exp0_q.size() == 0 && exp1_q.size() == 0 && in_ready0 && in_ready1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("drain_timeout", W'(0), W'(1));
  endtask

  task automatic reset_abort();
    logic [W-1:0] d;
    d = {$urandom, $urandom};
    send(d, '1, m_state(d, '1), 1'b0);
    repeat (3) @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    chk("rst_out_valid0", W'(out_valid0), W'(0));
    chk("rst_out_valid1", W'(out_valid1), W'(0));
    chk("rst_in_ready0", W'(in_ready0), W'(1));
    chk("rst_in_ready1", W'(in_ready1), W'(1));
    chk("rst_out_data0", out_data0, W'(0));
    chk("rst_out_data1", out_data1, W'(0));
    exp0_q.delete(); exp1_q.delete();
    acc0_q.delete(); acc1_q.delete();
    tag0_q.delete(); tag1_q.delete();
    pv = '{1'b0, 1'b0};
    phs = '{1'b0, 1'b0};
    #2;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] hv_in  [8];
  logic [5:0] hv_out [8];

  initial begin
    logic [W-1:0] d, e;
    int n, nseen;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; out_ready = 1'b1;
    #1;
    chk("reset_in_ready0", W'(in_ready0), W'(1));
    chk("reset_in_ready1", W'(in_ready1), W'(1));
    chk("reset_out_valid0", W'(out_valid0), W'(0));
    chk("reset_busy1", W'(busy1), W'(0));
    chk("reset_out_data0", out_data0, W'(0));
    chk("reset_out_data1", out_data1, W'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // zero state, fixed points 0 and 1
    send('0, '1, '0, 1'b0);
    send({L{6'h01}}, '1, {L{6'h01}}, 1'b0);
    for (int k = 0; k < L; k++) d[6*k +: 6] = 6'(k % 2);
    send(d, '1, d, 1'b0);

    // hand-computed lanes: S(2)=0A, S(4)=07, S(32)=04
    hv_in  = '{6'd0, 6'd1, 6'd2, 6'd4, 6'd32, 6'd0, 6'd1, 6'd2};
    hv_out = '{6'h00, 6'h01, 6'h0A, 6'h07, 6'h04, 6'h00, 6'h01, 6'h0A};
    for (int k = 0; k < L; k++) begin
      d[6*k +: 6] = hv_in[k];
      e[6*k +: 6] = hv_out[k];
    end
    send(d, '1, e, 1'b0);
    wait_drain();

    // all 64 inputs across 8 back-to-back states
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < L; k++) d[6*k +: 6] = 6'(8 * j + k);
      send(d, '1, m_state(d, '1), 1'b1);
    end
    wait_drain();

    // partial mask: even lanes substituted, odd lanes pass through
    for (int r = 0; r < 2; r++) begin
      d = {$urandom, $urandom};
      send(d, 8'h55, m_state(d, 8'h55), 1'b0);
    end
    wait_drain();

    // backpressure in DONE with ignored in_valid pulses
    out_ready = 1'b0;
    d = {$urandom, $urandom};
    send(d, '1, m_state(d, '1), 1'b0);
    n = 0;
    while (!(out_valid0 && out_valid1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("done_timeout", W'(0), W'(1));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i % 4 == 1);
      in_data  = {$urandom, $urandom};
      in_mask  = 8'($urandom);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    d = {$urandom, $urandom};
    send(d, 8'hA3, m_state(d, 8'hA3), 1'b0);
    chk("accept_after_handshake", W'(last_acc), W'(hs_cyc1 + 1));
    wait_drain();

    // asynchronous abort mid-RUN, then normal operation resumes
    reset_abort();
    d = {$urandom, $urandom};
    send(d, 8'h3C, m_state(d, 8'h3C), 1'b0);
    wait_drain();
    reset_abort();
    send({L{6'h02}}, '1, {L{6'h0A}}, 1'b0);
    wait_drain();

    // ---------------- final report ----------------
    nseen = 0;
    for (int i = 0; i < 64; i++) nseen += seen[i] ? 1 : 0;
    chk("permutation_count", W'(nseen), W'(64));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
